// File: rtl/occupancy_pkg.sv
// Shared widths, converter state encoding and the shift-add-3 step used by the
// occupancy counter and its sequential binary-to-BCD converter.
package occupancy_pkg;

  localparam int COUNT_W    = 14;
  localparam int BCD_W      = 16;
  localparam int BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_e;

  // One double-dabble iteration: bump every digit >= 5 by 3, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] bcd,
                                                 input logic             bit_in);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter: LOAD, 14 SHIFT cycles, DONE.
// bcd_o changes only in DONE, so partial digits are never visible.
module bin2bcd_seq
  import occupancy_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [COUNT_W-1:0] bin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam int ITER_W = $clog2(COUNT_W);

  conv_state_e        state_q;
  logic [COUNT_W-1:0] bin_q;
  logic [BCD_W-1:0]   work_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [ITER_W-1:0]  iter_q;
  logic               done_q;
  logic [BCD_W-1:0]   step_d;

  assign step_d = bcd_step(work_q, bin_q[COUNT_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) state_q <= LOAD;
        LOAD: begin
          bin_q   <= bin_i;
          work_q  <= '0;
          iter_q  <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          work_q <= step_d;
          bin_q  <= bin_q << 1;
          iter_q <= iter_q + 1'b1;
          if (iter_q == ITER_W'(COUNT_W - 1)) begin
            bcd_q   <= step_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= start_i ? LOAD : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/occupancy_bcd_counter.sv
// Room occupancy counter: synchronised entry/exit sensors drive a saturating
// binary count, mirrored to BCD for a 4-digit display.
module occupancy_bcd_counter
  import occupancy_pkg::*;
#(
  parameter int MAX_OCC = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_entry,
  input  logic               sensor_exit,
  output logic [COUNT_W-1:0] count_bin,
  output logic [BCD_W-1:0]   bcd_out,
  output logic               bcd_valid,
  output logic               full,
  output logic               empty
);

  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_OCC);

  logic [1:0]         entry_sync_q, exit_sync_q;
  logic               entry_prev_q, exit_prev_q;
  logic               entry_p_q, exit_p_q;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               full_q, empty_q;
  logic               change_q, pending_q;
  logic               conv_busy, conv_done;

  // NOTE: always_comb starts from a default so every path assigns count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({entry_p_q, exit_p_q})
      2'b10:   if (count_q < MAX_CNT) count_d = count_q + 1'b1;
      2'b01:   if (count_q != '0) count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_sync_q <= '0;
      exit_sync_q  <= '0;
      entry_prev_q <= 1'b0;
      exit_prev_q  <= 1'b0;
      entry_p_q    <= 1'b0;
      exit_p_q     <= 1'b0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      change_q     <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      entry_sync_q <= {entry_sync_q[0], sensor_entry};
      exit_sync_q  <= {exit_sync_q[0], sensor_exit};
      entry_prev_q <= entry_sync_q[1];
      exit_prev_q  <= exit_sync_q[1];
      entry_p_q    <= entry_sync_q[1] & ~entry_prev_q;
      exit_p_q     <= exit_sync_q[1] & ~exit_prev_q;
      count_q      <= count_d;
      full_q       <= (count_d == MAX_CNT);
      empty_q      <= (count_d == '0);
      change_q     <= (count_d != count_q);
      // A change during an in-flight conversion is remembered and replayed from DONE.
      if (conv_done)                   pending_q <= 1'b0;
      else if (change_q && conv_busy)  pending_q <= 1'b1;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (change_q | pending_q),
    .bin_i   (count_q),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd_out)
  );

  assign count_bin = count_q;
  assign bcd_valid = conv_done;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_occupancy_bcd_counter.sv
// Scoreboard bench: stimulus pushes expected BCD words, monitors pop on bcd_valid.
module tb_occupancy_bcd_counter;

  logic        clk = 1'b0;
  logic        reset, sensor_entry, sensor_exit;
  logic        rst5, entry5, exit5;
  logic [13:0] count_bin, count5;
  logic [15:0] bcd_out, bcd5;
  logic        bcd_valid, valid5, full, full5, empty, empty5;

  int checks = 0;
  int failures = 0;
  int occ = 0;
  int occ5 = 0;
  int exp_q[$];
  int exp5_q[$];
  int n_valid = 0;
  int n_valid5 = 0;
  bit mon_en = 1'b1;

  always #5 clk = ~clk;

  occupancy_bcd_counter dut (
    .clk(clk), .reset(reset), .sensor_entry(sensor_entry), .sensor_exit(sensor_exit),
    .count_bin(count_bin), .bcd_out(bcd_out), .bcd_valid(bcd_valid), .full(full), .empty(empty)
  );

  occupancy_bcd_counter #(.MAX_OCC(5)) dut5 (
    .clk(clk), .reset(rst5), .sensor_entry(entry5), .sensor_exit(exit5),
    .count_bin(count5), .bcd_out(bcd5), .bcd_valid(valid5), .full(full5), .empty(empty5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic logic digits_ok(input logic [15:0] b);
    return (b[15:12] <= 9) && (b[11:8] <= 9) && (b[7:4] <= 9) && (b[3:0] <= 9);
  endfunction

  always @(negedge clk) begin
    if (reset && bcd_valid) begin
      n_valid++;
      if (mon_en) begin
        check("bcd_digits", 32'(digits_ok(bcd_out)), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got 0x%0h expected no pulse", bcd_out);
        end else check("bcd_out", 32'(bcd_out), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst5 && valid5) begin
      n_valid5++;
      if (exp5_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid5: got 0x%0h expected no pulse", bcd5);
      end else check("bcd5_out", 32'(bcd5), 32'(exp5_q.pop_front()));
    end
  end

  task automatic pulse(input bit en, input bit ex, input int hold);
    @(negedge clk);
    sensor_entry = en;
    sensor_exit  = ex;
    repeat (hold) @(negedge clk);
    sensor_entry = 1'b0;
    sensor_exit  = 1'b0;
  endtask

  // Reference: entry alone saturates at the ceiling, exit alone floors at 0, both cancel.
  task automatic event_op(input bit en, input bit ex);
    if (en && !ex && occ < 9999) begin
      occ++;
      exp_q.push_back(to_bcd(occ));
    end else if (ex && !en && occ > 0) begin
      occ--;
      exp_q.push_back(to_bcd(occ));
    end
    pulse(en, ex, $urandom_range(1, 4));
    repeat (25) @(negedge clk);
    check("count_bin", 32'(count_bin), 32'(occ));
    check("empty", 32'(empty), 32'(occ == 0));
  endtask

  task automatic event5(input bit en);
    if (en && occ5 < 5) begin
      occ5++;
      exp5_q.push_back(to_bcd(occ5));
    end else if (!en && occ5 > 0) begin
      occ5--;
      exp5_q.push_back(to_bcd(occ5));
    end
    @(negedge clk);
    entry5 = en;
    exit5  = !en;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    entry5 = 1'b0;
    exit5  = 1'b0;
    repeat (25) @(negedge clk);
    check("count5", 32'(count5), 32'(occ5));
    check("full5", 32'(full5), 32'(occ5 == 5));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset = 1'b0; rst5 = 1'b0;
    sensor_entry = 1'b0; sensor_exit = 1'b0; entry5 = 1'b0; exit5 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count_bin), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'h0000);
    check("rst_valid", 32'(bcd_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    reset = 1'b1; rst5 = 1'b1;
    repeat (2) @(negedge clk);

    // Exit at zero must not wrap nor start a conversion.
    n0 = n_valid;
    event_op(1'b0, 1'b1);
    check("exit_at_zero_no_valid", 32'(n_valid - n0), 32'd0);

    // First entry: exact latency of count and BCD, and a long hold gives one event.
    @(negedge clk);
    sensor_entry = 1'b1;
    occ++;
    exp_q.push_back(to_bcd(occ));
    repeat (3) @(posedge clk);
    #1 check("latency_edge2", 32'(count_bin), 32'(occ - 1));
    @(posedge clk);
    #1 check("latency_edge3", 32'(count_bin), 32'(occ));
    repeat (15) @(posedge clk);
    #1 check("bcd_hold_edge15", 32'(bcd_out), 32'(to_bcd(occ - 1)));
    @(posedge clk);
    #1 check("bcd_latency16", 32'(bcd_out), 32'(to_bcd(occ)));
    check("valid_latency16", 32'(bcd_valid), 32'd1);
    repeat (10) @(negedge clk);
    sensor_entry = 1'b0;
    repeat (10) @(negedge clk);
    check("held_one_event", 32'(count_bin), 32'(occ));

    event_op(1'b1, 1'b0);
    event_op(1'b1, 1'b0);
    check("three_entries_bcd", 32'(bcd_out), 32'h0003);
    check("three_entries_valids", 32'(n_valid), 32'd3);
    check("three_entries_empty", 32'(empty), 32'd0);

    // Simultaneous entry and exit at 7 cancels with no conversion.
    repeat (4) event_op(1'b1, 1'b0);
    n0 = n_valid;
    pulse(1'b1, 1'b1, 2);
    repeat (20) @(negedge clk);
    check("both_count", 32'(count_bin), 32'd7);
    check("both_no_valid", 32'(n_valid - n0), 32'd0);

    for (int i = 0; i < 24; i++) begin
      int op;
      op = $urandom_range(0, 3);
      event_op(op == 0 || op == 1 || op == 3, op == 2 || op == 3);
    end
    if (occ == 0) event_op(1'b1, 1'b0);

    // Ceiling of 5 on the second instance.
    repeat (7) event5(1'b1);
    check("sat_bcd5", 32'(bcd5), 32'h0005);
    event5(1'b0);
    check("after_exit_bcd5", 32'(bcd5), 32'h0004);

    // Abort mid-SHIFT: bcd_out clears at once and no pulse follows.
    @(negedge clk);
    sensor_entry = 1'b1;
    repeat (13) @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    occ = 0;
    #1;
    check("abort_bcd", 32'(bcd_out), 32'h0000);
    check("abort_count", 32'(count_bin), 32'd0);
    check("abort_valid", 32'(bcd_valid), 32'd0);
    sensor_entry = 1'b0;
    repeat (3) @(negedge clk);
    n0 = n_valid;
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_valid", 32'(n_valid - n0), 32'd0);
    check("abort_count_after", 32'(count_bin), 32'd0);

    // Sensor already high at reset release counts once.
    sensor_entry = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    occ = 1;
    exp_q.push_back(to_bcd(1));
    reset = 1'b1;
    repeat (5) @(negedge clk);
    sensor_entry = 1'b0;
    repeat (25) @(negedge clk);
    check("high_at_release", 32'(count_bin), 32'd1);

    // Preload to 1233 with the scoreboard muted, then exercise the pending path.
    mon_en = 1'b0;
    for (int i = 1; i < 1233; i++) pulse(1'b1, 1'b0, 1);
    occ = 1233;
    repeat (40) @(negedge clk);
    exp_q.delete();
    check("preload_count", 32'(count_bin), 32'd1233);
    check("preload_bcd", 32'(bcd_out), 32'h1233);
    mon_en = 1'b1;
    n0 = n_valid;
    exp_q.push_back(to_bcd(1234));
    exp_q.push_back(to_bcd(1235));
    occ = 1235;
    @(negedge clk);
    sensor_entry = 1'b1;
    @(negedge clk);
    sensor_entry = 1'b0;
    repeat (3) @(negedge clk);
    sensor_entry = 1'b1;
    @(negedge clk);
    sensor_entry = 1'b0;
    repeat (60) @(negedge clk);
    check("pending_valids", 32'(n_valid - n0), 32'd2);
    check("pending_count", 32'(count_bin), 32'd1235);
    check("pending_bcd", 32'(bcd_out), 32'h1235);

    check("scoreboard_drained", 32'(exp_q.size() + exp5_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/occupancy_bcd_counter.md
OCCUPANCY_BCD_COUNTER -- requirements
Module: occupancy_bcd_counter

Interface
REQ-001 SHALL have parameter MAX_OCC, default 9999: occupancy ceiling, legal range 1..9999.
REQ-002 SHALL have port clk, input, 1: single system clock; all flops on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port sensor_entry, input, 1: asynchronous entry sensor, level, high = person present.
REQ-005 SHALL have port sensor_exit, input, 1: asynchronous exit sensor, same convention.
REQ-006 SHALL have port count_bin, output, 14: current occupancy, binary.
REQ-007 SHALL have port bcd_out, output, 16: occupancy as 4 BCD digits, [15:12] thousands ... [3:0] units; drives display bcd_in directly.
REQ-008 SHALL have port bcd_valid, output, 1: one-cycle pulse when bcd_out is updated.
REQ-009 SHALL have port full, output, 1: high while count_bin == MAX_OCC.
REQ-010 SHALL have port empty, output, 1: high while count_bin == 0.

Function
REQ-011 Each sensor SHALL pass through a 2-flop synchronizer, then a rising-edge detector producing a 1-cycle pulse (entry_p, exit_p).
REQ-012 count_bin SHALL update on the 3rd rising clk edge after the one that first samples a sensor high; that input held high SHALL yield exactly one event.
REQ-013 entry_p alone, count < MAX_OCC: count_bin +1.
REQ-014 entry_p alone, count == MAX_OCC: count unchanged (saturate); no wrap to 0.
REQ-015 exit_p alone, count > 0: count_bin -1.
REQ-016 exit_p alone, count == 0: count unchanged; no wrap to MAX_OCC.
REQ-017 entry_p and exit_p in the same cycle: count unchanged, no conversion triggered.
REQ-018 full and empty SHALL be registered flags updated on the same edge as count_bin.
REQ-019 Any change of count_bin SHALL request a binary-to-BCD conversion (shift-add-3, 14 iterations).
REQ-020 Converter FSM states: IDLE -> LOAD (1 cycle, capture count_bin) -> SHIFT (14 cycles) -> DONE (1 cycle) -> IDLE.
REQ-021 In DONE, bcd_out SHALL be written atomically and bcd_valid pulsed high for that cycle only.
REQ-022 Latency: bcd_out SHALL equal the new count 16 cycles after the edge on which count_bin changed, absent further changes.
REQ-023 bcd_out SHALL hold its previous value during conversion; no partial digits visible.
REQ-024 A count change while not in IDLE SHALL set a pending flag; on DONE with pending set, FSM SHALL go to LOAD (clearing pending) instead of IDLE, converting the latest count_bin.
REQ-025 Every bcd_out digit SHALL be in 0..9 at all times.

Reset
REQ-026 reset low SHALL asynchronously force: count_bin 0, bcd_out 16'h0000, bcd_valid 0, full 0, empty 1, FSM IDLE, pending 0, all synchronizer and edge flops 0.
REQ-027 A sensor already high at reset release SHALL count as one event (synchronizer flops reset to 0).
REQ-028 Reset asserted mid-conversion SHALL abort it; no bcd_valid pulse SHALL follow the abort.

Structure
REQ-029 Shared package occupancy_pkg SHALL hold: COUNT_W = 14, BCD_W = 16, BCD_DIGITS = 4, converter FSM state enum (IDLE, LOAD, SHIFT, DONE).
REQ-030 Conversion SHALL live in sub-module bin2bcd_seq (start/busy/done handshake, 14-bit in, 16-bit out); sync/edge/counter logic stays in the top.

Verification
REQ-031 Reset, then 3 entry pulses -> count_bin 3, bcd_out 16'h0003, exactly 3 bcd_valid pulses, empty 0.
REQ-032 MAX_OCC=5, 7 entry pulses -> count_bin stops at 5, full 1, bcd_out 16'h0005; 1 exit -> 16'h0004, full 0.
REQ-033 From 0, exit pulse -> count_bin 0, empty 1, no bcd_valid pulse.
REQ-034 Entry and exit rising on the same clk edge at count 7 -> count_bin 7, no bcd_valid within 20 cycles.
REQ-035 Preload 1233, two entries 4 cycles apart -> bcd_valid for 16'h1234, then final bcd_out 16'h1235 (pending path).
REQ-036 reset low at SHIFT cycle 8 of a conversion -> bcd_out 16'h0000 immediately, no bcd_valid after release.
